// File: rtl/uart_alu_pkg.sv
// Shared definitions for the UART <-> ALU client: data/opcode widths and FSM state encoding.
package uart_alu_pkg;

    localparam int unsigned NB_DATA_DFLT = 8;
    localparam int unsigned NB_OP_DFLT   = 6;
    localparam int unsigned NB_STATE     = 3;

    localparam logic [NB_STATE-1:0] ST_GET_A   = 3'd0;
    localparam logic [NB_STATE-1:0] ST_GET_B   = 3'd1;
    localparam logic [NB_STATE-1:0] ST_GET_OP  = 3'd2;
    localparam logic [NB_STATE-1:0] ST_COMPUTE = 3'd3;
    localparam logic [NB_STATE-1:0] ST_SEND    = 3'd4;

    typedef enum logic [NB_STATE-1:0] {
        GET_A   = ST_GET_A,
        GET_B   = ST_GET_B,
        GET_OP  = ST_GET_OP,
        COMPUTE = ST_COMPUTE,
        SEND    = ST_SEND
    } state_t;

    // True in the states that pop a request byte from the RX FIFO.
    function automatic logic is_get_state(input state_t s);
        return (s == GET_A) || (s == GET_B) || (s == GET_OP);
    endfunction

    // True in the states where a partial request is waiting for its next byte.
    function automatic logic is_partial_state(input state_t s);
        return (s == GET_B) || (s == GET_OP);
    endfunction

endpackage

// File: rtl/uart_if_timeout_counter.sv
// Idle-cycle counter for a partial request; expire_c pulses on the cycle the count reaches its limit.
module uart_if_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMEOUT     = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire_c
);

    localparam logic [NB_TIMEOUT-1:0] LAST = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

    logic [NB_TIMEOUT-1:0] count;

    assign expire_c = enable && !clear && (count == LAST);

    // Count idle cycles; restart on clear or on expiry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || expire_c) begin
            count <= '0;
        end else if (enable) begin
            count <= count + NB_TIMEOUT'(1);
        end
    end

endmodule

// File: rtl/uart_alu_interface.sv
// Client on the UART core FIFOs: pops A, B, opcode; presents them to the ALU; pushes the result.
// Optional partial-request timeout enabled by defining UART_IF_TIMEOUT_EN.
module uart_alu_interface
    import uart_alu_pkg::*;
#(
    parameter int unsigned NB_DATA        = NB_DATA_DFLT,
    parameter int unsigned NB_OP          = NB_OP_DFLT,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int unsigned NB_TIMEOUT     = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_rx_empty,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_tx_full,
    input  logic [NB_DATA-1:0] i_alu_result,
    output logic               o_read_uart,
    output logic               o_write_uart,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_alu_data_a,
    output logic [NB_DATA-1:0] o_alu_data_b,
    output logic [NB_OP-1:0]   o_alu_op,
    output logic               o_timeout
);

    state_t state;
    logic   running_q;
    logic   pop_c;
    logic   push_c;
    logic   expire_c;

    // Opcode byte upper bits are intentionally dropped.
    logic unused_rx_hi;
    assign unused_rx_hi = ^i_rx_data[NB_DATA-1:NB_OP];

    // Strobes stay low while reset is held (running_q is cleared asynchronously).
    assign pop_c        = running_q && is_get_state(state) && !i_rx_empty;
    assign push_c       = running_q && (state == SEND) && !i_tx_full;
    assign o_read_uart  = pop_c;
    assign o_write_uart = push_c;

`ifdef UART_IF_TIMEOUT_EN
    logic tmo_clear_c;
    logic tmo_enable_c;

    assign tmo_enable_c = is_partial_state(state) && i_rx_empty;
    assign tmo_clear_c  = pop_c || !is_partial_state(state);

    uart_if_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .NB_TIMEOUT     (NB_TIMEOUT)
    ) u_timeout (
        .clk      (i_clk),
        .rst_n    (i_reset),
        .clear    (tmo_clear_c),
        .enable   (tmo_enable_c),
        .expire_c (expire_c)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{TIMEOUT_CYCLES, NB_TIMEOUT};
    assign expire_c = 1'b0;
`endif

    // Gate strobes off until the first clock edge after reset release.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            running_q <= 1'b0;
        end else begin
            running_q <= 1'b1;
        end
    end

    // Request sequencer with registered operand, opcode, result and timeout pulse.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state        <= GET_A;
            o_tx_data    <= '0;
            o_alu_data_a <= '0;
            o_alu_data_b <= '0;
            o_alu_op     <= '0;
            o_timeout    <= 1'b0;
        end else begin
            o_timeout <= 1'b0;
            case (state)
                GET_A: begin
                    if (pop_c) begin
                        o_alu_data_a <= i_rx_data;
                        state        <= GET_B;
                    end
                end
                GET_B: begin
                    if (pop_c) begin
                        o_alu_data_b <= i_rx_data;
                        state        <= GET_OP;
                    end else if (expire_c) begin
                        o_timeout <= 1'b1;
                        state     <= GET_A;
                    end
                end
                GET_OP: begin
                    if (pop_c) begin
                        o_alu_op <= i_rx_data[NB_OP-1:0];
                        state    <= COMPUTE;
                    end else if (expire_c) begin
                        o_timeout <= 1'b1;
                        state     <= GET_A;
                    end
                end
                COMPUTE: begin
                    o_tx_data <= i_alu_result;
                    state     <= SEND;
                end
                SEND: begin
                    if (push_c) begin
                        state <= GET_A;
                    end
                end
                default: begin
                    state <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface with FIFO and ALU behavioural models.
module tb_uart_alu_interface;

    localparam int unsigned NB_DATA = 8;
    localparam int unsigned NB_OP   = 6;

    logic               clk = 1'b0;
    logic               i_reset;
    logic               i_rx_empty;
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_tx_full;
    logic [NB_DATA-1:0] i_alu_result;
    logic               o_read_uart;
    logic               o_write_uart;
    logic [NB_DATA-1:0] o_tx_data;
    logic [NB_DATA-1:0] o_alu_data_a;
    logic [NB_DATA-1:0] o_alu_data_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic               o_timeout;

    always #5 clk = ~clk;

    uart_alu_interface #(
        .NB_DATA        (NB_DATA),
        .NB_OP          (NB_OP),
        .TIMEOUT_CYCLES (16),
        .NB_TIMEOUT     (20)
    ) dut (
        .i_clk        (clk),
        .i_reset      (i_reset),
        .i_rx_empty   (i_rx_empty),
        .i_rx_data    (i_rx_data),
        .i_tx_full    (i_tx_full),
        .i_alu_result (i_alu_result),
        .o_read_uart  (o_read_uart),
        .o_write_uart (o_write_uart),
        .o_tx_data    (o_tx_data),
        .o_alu_data_a (o_alu_data_a),
        .o_alu_data_b (o_alu_data_b),
        .o_alu_op     (o_alu_op),
        .o_timeout    (o_timeout)
    );

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            default: return 8'h00;
        endcase
    endfunction

    always_comb i_alu_result = alu_model(o_alu_data_a, o_alu_data_b, o_alu_op);

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] op;
        logic [7:0] res;
    } vec_t;

    vec_t       vecs[6];
    logic [7:0] rx_q[$];
    int         total = 0;
    int         bad = 0;
    int         pops = 0;
    int         pushes = 0;
    int         to_count = 0;
    logic       hold_empty = 1'b0;
    logic [7:0] last_tx = 8'h00;
    logic       last_rd;
    logic       last_wr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive_rx();
        i_rx_empty = hold_empty || (rx_q.size() == 0);
        i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
    endtask

    // One clock: sample strobes at negedge, apply FIFO effects just after posedge.
    task automatic tick();
        logic       rd;
        logic       wr;
        logic [7:0] txd;
        @(negedge clk);
        rd  = o_read_uart;
        wr  = o_write_uart;
        txd = o_tx_data;
        if (o_timeout) to_count++;
        check("strobe_excl", {31'b0, rd && wr}, 32'd0);
        last_rd = rd;
        last_wr = wr;
        @(posedge clk);
        #1;
        if (rd) begin
            void'(rx_q.pop_front());
            pops++;
        end
        if (wr) begin
            last_tx = txd;
            pushes++;
        end
        drive_rx();
    endtask

    task automatic wait_push(output int lat);
        int p0;
        p0  = pushes;
        lat = 0;
        while (pushes == p0 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_req(input vec_t v);
        int lat;
        int p0;
        p0 = pops;
        rx_q.push_back(v.a);
        rx_q.push_back(v.b);
        rx_q.push_back(v.opb);
        drive_rx();
        wait_push(lat);
        check("req_latency", lat, 5);
        check("req_pops", pops - p0, 3);
        check("req_a", {24'b0, o_alu_data_a}, {24'b0, v.a});
        check("req_b", {24'b0, o_alu_data_b}, {24'b0, v.b});
        check("req_op", {26'b0, o_alu_op}, {26'b0, v.op});
        check("req_result", {24'b0, last_tx}, {24'b0, v.res});
    endtask

    initial begin
        logic [9:0] rd_seq;
        logic [9:0] wr_seq;
        int         lat;
        int         p0;
        int         unstable;
        int         first_j;

        vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, op: 6'h20, res: 8'h08};
        vecs[1] = '{a: 8'h0F, b: 8'h01, opb: 8'hE2, op: 6'h22, res: 8'h0E};
        vecs[2] = '{a: 8'hF0, b: 8'h3C, opb: 8'h24, op: 6'h24, res: 8'h30};
        vecs[3] = '{a: 8'hA5, b: 8'h5A, opb: 8'h65, op: 6'h25, res: 8'hFF};
        vecs[4] = '{a: 8'hC3, b: 8'hFF, opb: 8'h26, op: 6'h26, res: 8'h3C};
        vecs[5] = '{a: 8'hFF, b: 8'h02, opb: 8'h20, op: 6'h20, res: 8'h01};

        i_reset   = 1'b0;
        i_tx_full = 1'b0;
        drive_rx();
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_data", {24'b0, o_tx_data}, 32'd0);
        check("rst_a", {24'b0, o_alu_data_a}, 32'd0);
        check("rst_b", {24'b0, o_alu_data_b}, 32'd0);
        check("rst_op", {26'b0, o_alu_op}, 32'd0);
        check("rst_timeout", {31'b0, o_timeout}, 32'd0);
        check("rst_strobes", {30'b0, o_read_uart, o_write_uart}, 32'd0);
        @(negedge clk);
        i_reset = 1'b1;
        tick();
        tick();

        // Table of complete requests.
        for (int i = 0; i < 6; i++) begin
            run_req(vecs[i]);
        end

        // TX FIFO full for 10 cycles while holding the result.
        i_tx_full = 1'b1;
        rx_q.push_back(8'h40);
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h20);
        drive_rx();
        p0 = pushes;
        repeat (4) tick();
        unstable = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (o_tx_data !== 8'h42) unstable++;
        end
        check("full_no_push", pushes - p0, 0);
        check("full_tx_stable", unstable, 0);
        i_tx_full = 1'b0;
        tick();
        check("full_release_push", pushes - p0, 1);
        check("full_release_data", {24'b0, last_tx}, 32'h42);
        repeat (3) tick();
        check("full_single_push", pushes - p0, 1);

        // Back-to-back requests with RX never empty.
        rx_q.push_back(8'h01);
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h20);
        rx_q.push_back(8'h09);
        rx_q.push_back(8'h04);
        rx_q.push_back(8'h22);
        drive_rx();
        for (int i = 0; i < 10; i++) begin
            tick();
            rd_seq[9-i] = last_rd;
            wr_seq[9-i] = last_wr;
            if (i == 4) check("b2b_first_result", {24'b0, last_tx}, 32'h03);
        end
        check("b2b_rd_pattern", {22'b0, rd_seq}, {22'b0, 10'b1110011100});
        check("b2b_wr_pattern", {22'b0, wr_seq}, {22'b0, 10'b0000100001});
        check("b2b_second_result", {24'b0, last_tx}, 32'h05);

        // Reset after operand A; a fresh request must follow.
        rx_q.push_back(8'h11);
        drive_rx();
        tick();
        check("mid_a_captured", {24'b0, o_alu_data_a}, 32'h11);
        rx_q.push_back(8'h07);
        drive_rx();
        #2;
        i_reset = 1'b0;
        #1;
        check("async_rst_a", {24'b0, o_alu_data_a}, 32'd0);
        check("async_rst_b", {24'b0, o_alu_data_b}, 32'd0);
        check("async_rst_op", {26'b0, o_alu_op}, 32'd0);
        check("async_rst_tx", {24'b0, o_tx_data}, 32'd0);
        check("async_rst_strobes", {30'b0, o_read_uart, o_write_uart}, 32'd0);
        hold_empty = 1'b1;
        drive_rx();
        @(negedge clk);
        i_reset = 1'b1;
        tick();
        tick();
        hold_empty = 1'b0;
        rx_q.push_back(8'h02);
        rx_q.push_back(8'h20);
        drive_rx();
        wait_push(lat);
        check("post_rst_latency", lat, 5);
        check("post_rst_a", {24'b0, o_alu_data_a}, 32'h07);
        check("post_rst_b", {24'b0, o_alu_data_b}, 32'h02);
        check("post_rst_result", {24'b0, last_tx}, 32'h09);

        // Partial request: only operand A arrives.
        rx_q.push_back(8'h33);
        drive_rx();
        tick();
        to_count = 0;
        first_j  = 0;
        p0       = pushes;
        for (int j = 1; j <= 40; j++) begin
            tick();
            if (to_count > 0 && first_j == 0) first_j = j;
        end
`ifdef UART_IF_TIMEOUT_EN
        check("timeout_cycle", first_j, 17);
        check("timeout_pulses", to_count, 1);
        check("timeout_keeps_a", {24'b0, o_alu_data_a}, 32'h33);
        run_req('{a: 8'h06, b: 8'h07, opb: 8'h20, op: 6'h20, res: 8'h0D});
`else
        check("no_timeout_pulse", to_count, 0);
        check("no_timeout_push", pushes - p0, 0);
        rx_q.push_back(8'h07);
        rx_q.push_back(8'h20);
        drive_rx();
        wait_push(lat);
        check("wait_forever_a", {24'b0, o_alu_data_a}, 32'h33);
        check("wait_forever_b", {24'b0, o_alu_data_b}, 32'h07);
        check("wait_forever_result", {24'b0, last_tx}, 32'h3A);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
